// File: rtl/cdc_hs_tx_if.sv
// Source-side handshake bundle for the toggle request/acknowledge CDC transmitter.
// The master is the environment (source plus destination ack); the slave is cdc_hs_tx.
interface cdc_hs_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] src_data;
  logic                 src_valid;
  logic                 src_ready;
  logic [BUS_WIDTH-1:0] tx_data;
  logic                 tx_req;
  logic                 rx_ack;
  logic                 tx_done;
  logic                 proto_err;

  modport master (
    output src_data, src_valid, rx_ack,
    input  src_ready, tx_data, tx_req, tx_done, proto_err
  );

  modport slave (
    input  src_data, src_valid, rx_ack,
    output src_ready, tx_data, tx_req, tx_done, proto_err
  );
endinterface

// File: rtl/cdc_hs_tx.sv
// Launching end of a toggle request/acknowledge bus CDC: captures a word, holds it
// on tx_data, toggles tx_req one cycle later and waits for the synchronized ack.
module cdc_hs_tx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input logic         CLK,
  input logic         RST,
  cdc_hs_tx_if.slave  hs_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_STAGES-1:0]   sync_q;
  logic [BUS_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                    tx_req_q, tx_req_d;
  logic                    tx_done_q, tx_done_d;
  logic                    proto_err_q, proto_err_d;
  logic                    ready_q, ready_d;
  logic                    ack_s;
  logic                    cap_s;

  assign ack_s = sync_q[NUM_STAGES-1];
  // ready_q already encodes "IDLE and ack matches req", so it doubles as the capture qualifier
  assign cap_s = (state_q == IDLE) && hs_if.src_valid && ready_q;

  // RX_ACK synchronizer chain
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= {NUM_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], hs_if.rx_ack};
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cap_s) state_d = SETUP;
        else       state_d = IDLE;
      end
      SETUP: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_s == tx_req_q) state_d = IDLE;
        else                   state_d = WAIT_ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    tx_data_d   = tx_data_q;
    tx_req_d    = tx_req_q;
    tx_done_d   = 1'b0;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (cap_s) tx_data_d = hs_if.src_data;
        else       tx_data_d = tx_data_q;
        if (ack_s != tx_req_q) proto_err_d = 1'b1;
        else                   proto_err_d = proto_err_q;
      end
      SETUP: tx_req_d = ~tx_req_q;
      WAIT_ACK: begin
        if (ack_s == tx_req_q) tx_done_d = 1'b1;
        else                   tx_done_d = 1'b0;
      end
      default: tx_done_d = 1'b0;
    endcase
    // Ready is registered: look one stage ahead in the synchronizer for the next ack value
    ready_d = (state_d == IDLE) && (sync_q[NUM_STAGES-2] == tx_req_d);
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_data_q   <= {BUS_WIDTH{1'b0}};
      tx_req_q    <= 1'b0;
      tx_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      tx_data_q   <= tx_data_d;
      tx_req_q    <= tx_req_d;
      tx_done_q   <= tx_done_d;
      proto_err_q <= proto_err_d;
      ready_q     <= ready_d;
    end
  end

  assign hs_if.tx_data   = tx_data_q;
  assign hs_if.tx_req    = tx_req_q;
  assign hs_if.tx_done   = tx_done_q;
  assign hs_if.proto_err = proto_err_q;
  assign hs_if.src_ready = ready_q;

endmodule
